// File: rtl/view_scheduler.sv
// view_scheduler: owns the parking-lot view register, arbitrates switch and
// button requests by fixed priority, forces a return to IDLE after a period
// of inactivity in the transient views, and muxes the sub-view displays.
module view_scheduler #(
  parameter int TICK_DIV       = 100000000,
  parameter int IDLE_TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_admin,
  input  logic        sw_member,
  input  logic        bt_park,
  input  logic        bt_leave,
  input  logic        num_correct,
  input  logic        pay_done,
  input  logic        activity,
  input  logic [47:0] seg_out_bus,
  input  logic [47:0] seg_en_bus,
  output logic [2:0]  view,
  output logic        view_enter,
  output logic        timeout_flag,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = (IDLE_TIMEOUT_S > 0) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LIMIT = SEC_W'(IDLE_TIMEOUT_S);

  typedef enum logic [2:0] {
    V_IDLE   = 3'd0,
    V_ADMIN  = 3'd1,
    V_PARK   = 3'd2,
    V_CHECK  = 3'd3,
    V_PAY    = 3'd4,
    V_MEMBER = 3'd5
  } view_t;

  // Kept as a plain vector so the illegal codes 6/7 remain representable.
  logic [2:0]        view_r;
  logic [2:0]        req_nx;
  logic [2:0]        view_nx;
  logic              req_fire;
  logic              transient;
  logic              expire;
  logic              cnt_clear;
  logic [TICK_W-1:0] tick_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [7:0]        seg_sel;
  logic [7:0]        en_sel;
  logic              enter_nx;
  logic              tflag_nx;

  assign transient = (view_r == V_PARK) || (view_r == V_CHECK) || (view_r == V_PAY);
  assign expire    = transient && (sec_cnt == SEC_LIMIT) && !activity;
  assign cnt_clear = activity || (view_nx != view_r) || !transient;
  assign view      = view_r;

  // State register plus the registered display and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      view_r       <= V_IDLE;
      view_enter   <= 1'b0;
      timeout_flag <= 1'b0;
      seg_out      <= 8'h00;
      seg_en       <= 8'h00;
    end else begin
      view_r       <= view_nx;
      view_enter   <= enter_nx;
      timeout_flag <= tflag_nx;
      seg_out      <= seg_sel;
      seg_en       <= en_sel;
    end
  end

  // Next view: per-view request rules by priority, then timeout override.
  always_comb begin
    req_nx = view_r;
    case (view_r)
      V_IDLE: begin
        if (sw_admin)       req_nx = V_ADMIN;
        else if (sw_member) req_nx = V_MEMBER;
        else if (bt_park)   req_nx = V_PARK;
        else if (bt_leave)  req_nx = V_CHECK;
      end
      V_ADMIN:  if (!sw_admin)  req_nx = V_IDLE;
      V_MEMBER: if (!sw_member) req_nx = V_IDLE;
      V_PARK:   if (bt_park)    req_nx = V_IDLE;
      V_CHECK: begin
        if (bt_park)          req_nx = V_IDLE;
        else if (num_correct) req_nx = V_PAY;
      end
      V_PAY:    if (pay_done)   req_nx = V_IDLE;
      default:                  req_nx = V_IDLE;
    endcase
    req_fire = (req_nx != view_r);
    view_nx  = expire ? V_IDLE : req_nx;
  end

  // Outputs: display slice of the current view and the change/timeout pulses.
  always_comb begin
    seg_sel  = 8'h00;
    en_sel   = 8'h00;
    if (view_r <= V_MEMBER) begin
      seg_sel = seg_out_bus[8*int'(view_r) +: 8];
      en_sel  = seg_en_bus[8*int'(view_r) +: 8];
    end
    enter_nx = (view_nx != view_r);
    tflag_nx = expire && !req_fire;
  end

  // Inactivity timer: ticks roll into seconds; seconds saturate at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (cnt_clear) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      if (sec_cnt != SEC_LIMIT) sec_cnt <= sec_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_view_scheduler.sv
// tb_view_scheduler: scoreboard bench for view_scheduler with small timer
// parameters; a behavioural model queues the expected outputs per cycle.
module tb_view_scheduler;

  localparam int TICK_DIV       = 4;
  localparam int IDLE_TIMEOUT_S = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_admin, sw_member, bt_park, bt_leave;
  logic        num_correct, pay_done, activity;
  logic [47:0] seg_out_bus, seg_en_bus;
  logic [2:0]  view;
  logic        view_enter, timeout_flag;
  logic [7:0]  seg_out, seg_en;

  typedef struct packed {
    logic [2:0] view;
    logic       enter;
    logic       tflag;
    logic [7:0] so;
    logic [7:0] se;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         misses  = 0;
  int         m_view, m_tick, m_sec;
  logic       m_enter, m_tflag;
  logic [7:0] m_so, m_se;
  int         lat;

  view_scheduler #(.TICK_DIV(TICK_DIV), .IDLE_TIMEOUT_S(IDLE_TIMEOUT_S)) dut (
    .clk(clk), .rst(rst),
    .sw_admin(sw_admin), .sw_member(sw_member),
    .bt_park(bt_park), .bt_leave(bt_leave),
    .num_correct(num_correct), .pay_done(pay_done), .activity(activity),
    .seg_out_bus(seg_out_bus), .seg_en_bus(seg_en_bus),
    .view(view), .view_enter(view_enter), .timeout_flag(timeout_flag),
    .seg_out(seg_out), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      misses++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_view = 0; m_tick = 0; m_sec = 0;
    m_enter = 1'b0; m_tflag = 1'b0; m_so = 8'h00; m_se = 8'h00;
    sb_q.delete();
  endtask

  // Expected behaviour of one clock edge given the inputs currently driven.
  task automatic model_edge();
    int nxt;
    bit fire, expire;
    nxt = m_view;
    case (m_view)
      0: if (sw_admin) nxt = 1; else if (sw_member) nxt = 5;
         else if (bt_park) nxt = 2; else if (bt_leave) nxt = 3;
      1: if (!sw_admin) nxt = 0;
      2: if (bt_park) nxt = 0;
      3: if (bt_park) nxt = 0; else if (num_correct) nxt = 4;
      4: if (pay_done) nxt = 0;
      5: if (!sw_member) nxt = 0;
      default: nxt = 0;
    endcase
    fire    = (nxt != m_view);
    expire  = (m_view >= 2 && m_view <= 4) && (m_sec == IDLE_TIMEOUT_S) && !activity;
    m_tflag = expire && !fire;
    if (expire) nxt = 0;
    m_enter = (nxt != m_view);
    if (m_view <= 5) begin
      m_so = seg_out_bus[8*m_view +: 8];
      m_se = seg_en_bus[8*m_view +: 8];
    end else begin
      m_so = 8'h00;
      m_se = 8'h00;
    end
    if (activity || m_enter || m_view == 0 || m_view == 1 || m_view == 5) begin
      m_tick = 0; m_sec = 0;
    end else if (m_tick == TICK_DIV - 1) begin
      m_tick = 0;
      if (m_sec < IDLE_TIMEOUT_S) m_sec++;
    end else begin
      m_tick++;
    end
    m_view = nxt;
    sb_q.push_back('{view: 3'(m_view), enter: m_enter, tflag: m_tflag, so: m_so, se: m_se});
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("view", {5'd0, view}, {5'd0, e.view});
      checkOutput("view_enter", {7'd0, view_enter}, {7'd0, e.enter});
      checkOutput("timeout_flag", {7'd0, timeout_flag}, {7'd0, e.tflag});
      checkOutput("seg_out", seg_out, e.so);
      checkOutput("seg_en", seg_en, e.se);
    end
  endtask

  // Called at a falling edge; p = {bt_park, bt_leave, num_correct, pay_done, activity}.
  // Pulses are applied on the first cycle only, switches hold for all n cycles.
  task automatic applyStimulus(input logic a, input logic m, input logic [4:0] p, input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      sw_admin  = a;
      sw_member = m;
      {bt_park, bt_leave, num_correct, pay_done, activity} = (i == 0) ? p : 5'd0;
      r = {$urandom(), $urandom()};
      seg_out_bus = r[47:0];
      r = {$urandom(), $urandom()};
      seg_en_bus = r[47:0];
      model_edge();
      @(posedge clk);
      #1;
      compare_pop();
      @(negedge clk);
    end
  endtask

  // Counts idle cycles until timeout_flag shows up, bounded.
  task automatic wait_timeout(output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 5'b00000, 1);
      cycles++;
    end while (timeout_flag !== 1'b1 && cycles < 40);
  endtask

  initial begin
    rst = 1'b0;
    {sw_admin, sw_member, bt_park, bt_leave, num_correct, pay_done, activity} = '0;
    seg_out_bus = 48'hA5A5_1234_5678;
    seg_en_bus  = 48'h5A5A_8765_4321;
    model_reset();
    #1;
    checkOutput("rst_view", {5'd0, view}, 8'd0);
    checkOutput("rst_enter", {7'd0, view_enter}, 8'd0);
    checkOutput("rst_tflag", {7'd0, timeout_flag}, 8'd0);
    checkOutput("rst_seg_out", seg_out, 8'h00);
    checkOutput("rst_seg_en", seg_en, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] park entry and display latency");
    applyStimulus(1'b0, 1'b0, 5'b10000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 2);
    applyStimulus(1'b0, 1'b0, 5'b10000, 2);

    $display("[TB] switch priority and admin/member hand-over");
    applyStimulus(1'b1, 1'b0, 5'b10000, 3);
    applyStimulus(1'b0, 1'b1, 5'b10000, 1);
    applyStimulus(1'b0, 1'b1, 5'b00000, 3);
    applyStimulus(1'b1, 1'b1, 5'b01000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 2);

    $display("[TB] check / pay flow");
    applyStimulus(1'b0, 1'b0, 5'b01000, 1);
    applyStimulus(1'b0, 1'b0, 5'b10100, 1);
    applyStimulus(1'b0, 1'b0, 5'b01000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00100, 1);
    applyStimulus(1'b0, 1'b0, 5'b11000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00010, 2);

    $display("[TB] inactivity timeout");
    applyStimulus(1'b0, 1'b0, 5'b10000, 1);
    wait_timeout(lat);
    checkOutput("timeout_latency", 8'(lat), 8'd13);
    applyStimulus(1'b0, 1'b0, 5'b10000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 9);
    applyStimulus(1'b0, 1'b0, 5'b00001, 1);
    wait_timeout(lat);
    checkOutput("timeout_restart", 8'(lat), 8'd13);
    applyStimulus(1'b0, 1'b0, 5'b10000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 12);
    applyStimulus(1'b0, 1'b0, 5'b00001, 2);
    applyStimulus(1'b0, 1'b0, 5'b10000, 1);
    applyStimulus(1'b0, 1'b0, 5'b01000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 12);
    applyStimulus(1'b0, 1'b0, 5'b10000, 2);

    $display("[TB] admin hold without timeout");
    applyStimulus(1'b1, 1'b0, 5'b00000, 50);
    applyStimulus(1'b0, 1'b0, 5'b00000, 2);

    $display("[TB] asynchronous reset in PAY");
    applyStimulus(1'b0, 1'b0, 5'b01000, 1);
    applyStimulus(1'b0, 1'b0, 5'b00100, 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_view", {5'd0, view}, 8'd0);
    checkOutput("async_seg_out", seg_out, 8'h00);
    checkOutput("async_seg_en", seg_en, 8'h00);
    checkOutput("async_enter", {7'd0, view_enter}, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'b00000, 2);

    $display("[TB] illegal view recovery");
    applyStimulus(1'b0, 1'b0, 5'b10000, 2);
    force dut.view_r = 3'd6;
    #1;
    release dut.view_r;
    m_view = 6;
    m_tick = 0;
    m_sec  = 0;
    applyStimulus(1'b0, 1'b0, 5'b00000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/view_scheduler.md
Name: view_scheduler

Overview:
- Central view sequencer and display arbiter for the parking-lot top level.
- Owns the 3-bit view register (idle/scroll, admin, park, number-check, pay, member).
- Resolves simultaneous switch and button requests by fixed priority and applies an inactivity timeout in the transient views.
- Muxes the six sub-view 7-segment buses onto the single display with registered outputs.

Parameters:
TICK_DIV, 100000000, clk cycles per 1-second tick
IDLE_TIMEOUT_S, 30, seconds without activity before forced return to view 0 (PARK/CHECK/PAY only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sw_admin  in  1  level, admin switch
sw_member  in  1  level, member switch
bt_park  in  1  debounced 1-cycle pulse; enter/leave park, back from check
bt_leave  in  1  debounced 1-cycle pulse; enter number-check
num_correct  in  1  1-cycle pulse from number checker
pay_done  in  1  1-cycle pulse from pay unit (final state reached)
activity  in  1  1-cycle pulse, any key/button press
seg_out_bus  in  48  {v5,v4,v3,v2,v1,v0} seg_out, 8 bits per view
seg_en_bus  in  48  same packing for seg_en
view  out  3  current view code
view_enter  out  1  1-cycle pulse after every view change
timeout_flag  out  1  1-cycle pulse when timeout forces view 0
seg_out  out  8  registered display segments
seg_en  out  8  registered digit enables

Behaviour:
- Reset (rst=0, async): view=0, view_enter=0, timeout_flag=0, seg_out=8'h00, seg_en=8'h00, tick and second counters=0.
- View codes: 0 IDLE, 1 ADMIN, 2 PARK, 3 CHECK, 4 PAY, 5 MEMBER. Codes 6/7 are illegal and go to 0 next cycle.
- IDLE transitions, highest priority first: sw_admin→ADMIN, sw_member→MEMBER, bt_park→PARK, bt_leave→CHECK.
- ADMIN: ~sw_admin→IDLE. Buttons are ignored.
- MEMBER: ~sw_member→IDLE. Buttons are ignored.
- PARK: bt_park→IDLE.
- CHECK: bt_park→IDLE, else num_correct→PAY. If both arrive in the same cycle, the back action (IDLE) wins.
- PAY: pay_done→IDLE.
- Transitions outside the current view's list are ignored.
- Leaving ADMIN or MEMBER into IDLE with the other switch already high: the next cycle's IDLE rules apply. There is no direct ADMIN↔MEMBER hop.
- Latency:
  - Request sampled at edge N; view updates at N.
  - view_enter=1 during cycle N..N+1.
  - seg_out/seg_en select the new view's slice at edge N+1.
- Display: at each edge, seg_out ← seg_out_bus[8*view +: 8] and seg_en ← seg_en_bus[8*view +: 8], using the registered view. Illegal view codes drive 8'h00.
- Timeout counters:
  - Tick counter runs 0..TICK_DIV-1. The second counter increments on wrap.
  - Both counters clear on activity, on any view change, and whenever view ∈ {IDLE, ADMIN, MEMBER}.
  - When the second counter reaches IDLE_TIMEOUT_S in PARK/CHECK/PAY, the next edge forces view=0 and pulses timeout_flag and view_enter together.
  - A timeout and a legal request in the same cycle both go to IDLE. timeout_flag is set only if no legal request fired.
  - activity in the same cycle as expiry cancels the timeout.
- Counter width: $clog2(TICK_DIV), and $clog2(IDLE_TIMEOUT_S+1). Neither counter wraps past the terminal value.
- Reset mid-transition: async clear overrides everything. A pending pulse is lost, which is intended.

Test Plan:
- Reset, then rst=1; pulse bt_park → view 0→2 at next edge, view_enter high 1 cycle, seg_out equals seg_out_bus[23:16] one cycle later.
- In IDLE raise sw_admin and pulse bt_park in the same cycle → view=1. Drop sw_admin → view=0, then with sw_member=1 → view=5 on the following edge.
- bt_leave → view=3. Pulse num_correct and bt_park together → view=0. Repeat with num_correct alone → view=4; pay_done → view=0.
- TICK_DIV=4, IDLE_TIMEOUT_S=3: enter PARK with no activity → view=0 with timeout_flag pulse exactly 12 cycles after entry (±1 documented edge). Activity at cycle 10 restarts the full 12-cycle count.
- In ADMIN for 50 cycles with the same small parameters → no timeout, timeout_flag stays 0.
- Assert rst=0 mid-PAY → view, seg_out and seg_en go to 0 immediately (async), with no view_enter pulse. Force view to 6 via a backdoor → returns to 0 next edge, seg_out=8'h00.
